// File: rtl/dmi_jtag_old.sv
// RISC-V Debug Transport Module for JTAG.
// Holds an IEEE 1149.1 TAP controller, a 5-bit IR and the IDCODE, DTMCS, DMI and BYPASS data
// registers, and turns DMI scans into valid/ready requests toward the Debug Module.
// All state lives in the tck_i domain; td_o/tdo_oe_o are launched on the falling edge.
//
// Ports:
//   tck_i, trst_i          JTAG clock, asynchronous active-high reset
//   tms_i, td_i, td_o      TAP mode select, TDI (LSB first), TDO
//   tdo_oe_o               TDO enable, high only while shifting IR or DR
//   dmi_clear_o            one-cycle DMI hard-reset pulse
//   dmi_req_o/_valid_o     request {addr, op, data}, held until dmi_req_ready_i
//   dmi_resp_i/_valid_i    response {data, resp}, accepted while dmi_resp_ready_o
module dmi_jtag_old #(
  parameter logic [31:0] IdcodeValue = 32'h0000_0001,
  parameter int unsigned AbitsWidth  = 7
) (
  input  logic                     tck_i,
  input  logic                     trst_i,
  input  logic                     tms_i,
  input  logic                     td_i,
  output logic                     td_o,
  output logic                     tdo_oe_o,
  output logic                     dmi_clear_o,
  output logic [AbitsWidth+33:0]   dmi_req_o,
  output logic                     dmi_req_valid_o,
  input  logic                     dmi_req_ready_i,
  input  logic [33:0]              dmi_resp_i,
  input  logic                     dmi_resp_valid_i,
  output logic                     dmi_resp_ready_o
);

  localparam int unsigned DmiWidth   = AbitsWidth + 34;
  localparam logic [5:0]  AbitsField = 6'(AbitsWidth);

  localparam logic [4:0] IrIdcode = 5'h01;
  localparam logic [4:0] IrDtmcs  = 5'h10;
  localparam logic [4:0] IrDmi    = 5'h11;

  typedef enum logic [3:0] {
    TestLogicReset, RunTestIdle,
    SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr, Exit2Dr, UpdateDr,
    SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr
  } tap_state_e;

  typedef enum logic [2:0] {
    DmiIdle, DmiRead, DmiWaitRead, DmiWrite, DmiWaitWrite
  } dmi_state_e;

  tap_state_e tap_q, tap_d;
  dmi_state_e dmi_state_q, dmi_state_d;

  logic [4:0]            ir_shift_q, ir_shift_d;
  logic [4:0]            ir_q, ir_d;
  logic [DmiWidth-1:0]   dr_q, dr_d;
  logic [AbitsWidth-1:0] addr_q, addr_d;
  logic [1:0]            op_q, op_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           last_data_q, last_data_d;
  logic [1:0]            error_q, error_d;
  logic                  clear_q, clear_d;

  // ---------------------------------------------------------------------------
  // TAP controller
  // ---------------------------------------------------------------------------
  always_comb begin
    tap_d = tap_q;
    unique case (tap_q)
      TestLogicReset: tap_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    tap_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   tap_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      tap_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        tap_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        tap_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        tap_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        tap_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       tap_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   tap_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      tap_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        tap_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        tap_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        tap_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        tap_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       tap_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        tap_d = TestLogicReset;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction register
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_d       = ir_q;
    unique case (tap_q)
      TestLogicReset: ir_d       = IrIdcode;
      CaptureIr:      ir_shift_d = 5'b00001;
      ShiftIr:        ir_shift_d = {td_i, ir_shift_q[4:1]};
      UpdateIr:       ir_d       = ir_shift_q;
      default: ;
    endcase
  end

  logic sel_idcode, sel_dtmcs, sel_dmi;
  assign sel_idcode = (ir_q == IrIdcode);
  assign sel_dtmcs  = (ir_q == IrDtmcs);
  assign sel_dmi    = (ir_q == IrDmi);

  logic dmi_busy;
  assign dmi_busy = (dmi_state_q != DmiIdle);

  logic [31:0] dtmcs_value;
  assign dtmcs_value = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, error_q, AbitsField, 4'd1};

  // ---------------------------------------------------------------------------
  // Shared data register: the selected DR occupies the low bits; 32-bit and
  // 1-bit registers take td_i at their own MSB so their length is exact.
  // ---------------------------------------------------------------------------
  always_comb begin
    dr_d = dr_q;
    if (tap_q == CaptureDr) begin
      if (sel_idcode) begin
        dr_d = {{(DmiWidth-32){1'b0}}, IdcodeValue};
      end else if (sel_dtmcs) begin
        dr_d = {{(DmiWidth-32){1'b0}}, dtmcs_value};
      end else if (sel_dmi) begin
        // A capture while a transaction is in flight reports busy in the op field.
        dr_d = {addr_q, last_data_q, (dmi_busy ? 2'b11 : error_q)};
      end else begin
        dr_d = '0;
      end
    end else if (tap_q == ShiftDr) begin
      if (sel_dmi) begin
        dr_d = {td_i, dr_q[DmiWidth-1:1]};
      end else if (sel_idcode || sel_dtmcs) begin
        dr_d[31:0] = {td_i, dr_q[31:1]};
      end else begin
        dr_d[0] = td_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // DMI request/response FSM
  // ---------------------------------------------------------------------------
  logic                  update_dmi, update_dtmcs;
  logic [1:0]            dr_op;
  logic [31:0]           dr_data;
  logic [AbitsWidth-1:0] dr_addr;

  assign update_dmi   = (tap_q == UpdateDr) && sel_dmi;
  assign update_dtmcs = (tap_q == UpdateDr) && sel_dtmcs;
  assign dr_op        = dr_q[1:0];
  assign dr_data      = dr_q[33:2];
  assign dr_addr      = dr_q[DmiWidth-1:34];

  always_comb begin
    dmi_state_d = dmi_state_q;
    addr_d      = addr_q;
    op_d        = op_q;
    data_d      = data_q;
    last_data_d = last_data_q;
    error_d     = error_q;
    clear_d     = 1'b0;

    unique case (dmi_state_q)
      DmiRead:  if (dmi_req_ready_i) dmi_state_d = DmiWaitRead;
      DmiWrite: if (dmi_req_ready_i) dmi_state_d = DmiWaitWrite;
      DmiWaitRead: begin
        if (dmi_resp_valid_i) begin
          last_data_d = dmi_resp_i[33:2];
          if (dmi_resp_i[1]) error_d = 2'd2;
          dmi_state_d = DmiIdle;
        end
      end
      DmiWaitWrite: begin
        if (dmi_resp_valid_i) begin
          if (dmi_resp_i[1]) error_d = 2'd2;
          dmi_state_d = DmiIdle;
        end
      end
      default: ;
    endcase

    if ((tap_q == CaptureDr) && sel_dmi && dmi_busy) error_d = 2'd3;

    if (update_dmi) begin
      if (dmi_busy) begin
        error_d = 2'd3;
      end else if (error_q == 2'd0) begin
        if (dr_op == 2'd1) begin
          addr_d      = dr_addr;
          op_d        = 2'd1;
          dmi_state_d = DmiRead;
        end else if (dr_op == 2'd2) begin
          addr_d      = dr_addr;
          data_d      = dr_data;
          op_d        = 2'd2;
          dmi_state_d = DmiWrite;
        end
      end
    end

    if (update_dtmcs) begin
      if (dr_q[16]) error_d = 2'd0;
      if (dr_q[17]) begin
        error_d     = 2'd0;
        dmi_state_d = DmiIdle;
        clear_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      tap_q       <= TestLogicReset;
      ir_shift_q  <= 5'b0;
      ir_q        <= IrIdcode;
      dr_q        <= '0;
      dmi_state_q <= DmiIdle;
      addr_q      <= '0;
      op_q        <= 2'b0;
      data_q      <= 32'b0;
      last_data_q <= 32'b0;
      error_q     <= 2'b0;
      clear_q     <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      ir_shift_q  <= ir_shift_d;
      ir_q        <= ir_d;
      dr_q        <= dr_d;
      dmi_state_q <= dmi_state_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      data_q      <= data_d;
      last_data_q <= last_data_d;
      error_q     <= error_d;
      clear_q     <= clear_d;
    end
  end

  // TDO launched on the falling edge so the host can sample it on the next rising edge.
  logic tdo_next;
  always_comb begin
    tdo_next = 1'b0;
    if (tap_q == ShiftIr)      tdo_next = ir_shift_q[0];
    else if (tap_q == ShiftDr) tdo_next = dr_q[0];
  end

  always_ff @(negedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      td_o     <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      td_o     <= tdo_next;
      tdo_oe_o <= (tap_q == ShiftIr) || (tap_q == ShiftDr);
    end
  end

  assign dmi_req_o        = {addr_q, op_q, data_q};
  assign dmi_req_valid_o  = (dmi_state_q == DmiRead) || (dmi_state_q == DmiWrite);
  assign dmi_resp_ready_o = (dmi_state_q == DmiWaitRead) || (dmi_state_q == DmiWaitWrite);
  assign dmi_clear_o      = clear_q;

endmodule

// File: tb/tb_dmi_jtag_old.sv
// Self-checking bench for dmi_jtag_old: table of IR/DR scans plus hand-written DMI sequences.
module tb_dmi_jtag_old;

  logic        tck_i = 1'b0;
  logic        trst_i, tms_i, td_i;
  logic        td_o, tdo_oe_o, dmi_clear_o;
  logic [40:0] dmi_req_o;
  logic        dmi_req_valid_o, dmi_req_ready_i;
  logic [33:0] dmi_resp_i;
  logic        dmi_resp_valid_i, dmi_resp_ready_o;

  int total = 0;
  int bad = 0;
  int clear_cnt = 0;

  always #10 tck_i = ~tck_i;

  dmi_jtag_old dut (
    .tck_i            (tck_i),
    .trst_i           (trst_i),
    .tms_i            (tms_i),
    .td_i             (td_i),
    .td_o             (td_o),
    .tdo_oe_o         (tdo_oe_o),
    .dmi_clear_o      (dmi_clear_o),
    .dmi_req_o        (dmi_req_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_resp_i       (dmi_resp_i),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o)
  );

  typedef struct {
    logic [4:0]  ir;
    int          nbits;
    logic [63:0] din;
    logic [63:0] dout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; samples TDO as the host would at the next rising edge.
  task automatic step(input logic tms, input logic tdi, output logic tdo, output logic oe);
    tms_i = tms;
    td_i  = tdi;
    tdo   = td_o;
    oe    = tdo_oe_o;
    if (dmi_clear_o) clear_cnt++;
    @(posedge tck_i);
    @(negedge tck_i);
    #1;
  endtask

  task automatic idle(input int n);
    logic b, oe;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, b, oe);
  endtask

  // Both scans start and end in Run-Test/Idle.
  task automatic scan_ir(input logic [4:0] val, output logic [4:0] cap);
    logic b, oe;
    step(1'b1, 1'b0, b, oe);
    step(1'b1, 1'b0, b, oe);
    step(1'b0, 1'b0, b, oe);
    step(1'b0, 1'b0, b, oe);
    for (int i = 0; i < 5; i++) begin
      step(i == 4, val[i], b, oe);
      cap[i] = b;
    end
    step(1'b1, 1'b0, b, oe);
    step(1'b0, 1'b0, b, oe);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                         output logic oe_ok);
    logic b, oe;
    oe_ok = 1'b1;
    dout  = '0;
    step(1'b1, 1'b0, b, oe); if (oe) oe_ok = 1'b0;
    step(1'b0, 1'b0, b, oe); if (oe) oe_ok = 1'b0;
    step(1'b0, 1'b0, b, oe); if (oe) oe_ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], b, oe);
      dout[i] = b;
      if (!oe) oe_ok = 1'b0;
    end
    step(1'b1, 1'b0, b, oe); if (oe) oe_ok = 1'b0;
    step(1'b0, 1'b0, b, oe);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [4:0]  cap;
    logic [63:0] dout;
    logic        oe_ok, b, oe;
    logic [40:0] wr_req, rd_req, exp41;

    wr_req = 41'h0401FFFFF06;
    rd_req = 41'h04000000001;

    vecs[0] = '{ir: 5'h01, nbits: 32, din: 64'h0, dout: 64'h0000_0001};
    vecs[1] = '{ir: 5'h10, nbits: 32, din: 64'h0, dout: 64'h0000_1071};
    vecs[2] = '{ir: 5'h01, nbits: 64, din: 64'hDEADBEEF_12345678, dout: 64'h12345678_00000001};
    vecs[3] = '{ir: 5'h1F, nbits: 8,  din: 64'hA5, dout: 64'h4A};
    vecs[4] = '{ir: 5'h05, nbits: 8,  din: 64'h3C, dout: 64'h78};
    vecs[5] = '{ir: 5'h11, nbits: 41, din: 64'h0, dout: 64'h0};
    vecs[6] = '{ir: 5'h10, nbits: 32, din: 64'h0, dout: 64'h0000_1071};

    trst_i = 1'b1; tms_i = 1'b1; td_i = 1'b0;
    dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0; dmi_resp_i = '0;
    @(negedge tck_i); #1;
    check("reset td_o", td_o, 0);
    check("reset tdo_oe", tdo_oe_o, 0);
    check("reset req_valid", dmi_req_valid_o, 0);
    check("reset resp_ready", dmi_resp_ready_o, 0);
    check("reset clear", dmi_clear_o, 0);
    check("reset req", dmi_req_o, 0);
    trst_i = 1'b0;
    @(negedge tck_i); #1;

    // Reset leaves IDCODE selected without any IR scan.
    step(1'b0, 1'b0, b, oe);
    scan_dr(32, 64'h0, dout, oe_ok);
    check("reset idcode", dout, 64'h1);
    check("reset idcode oe", oe_ok, 1);

    for (int i = 0; i < 7; i++) begin
      scan_ir(vecs[i].ir, cap);
      check($sformatf("vec%0d ir capture", i), cap, 5'b00001);
      scan_dr(vecs[i].nbits, vecs[i].din, dout, oe_ok);
      check($sformatf("vec%0d dr out", i), dout, vecs[i].dout);
      check($sformatf("vec%0d oe", i), oe_ok, 1);
    end

    // DMI write, held until ready, then response.
    scan_ir(5'h11, cap);
    scan_dr(41, 64'(wr_req), dout, oe_ok);
    check("wr capture", dout, 0);
    check("wr valid", dmi_req_valid_o, 1);
    check("wr req", dmi_req_o, {7'h10, 2'd2, 32'h07FFFFC1});
    idle(1);
    check("wr held valid", dmi_req_valid_o, 1);
    check("wr held req", dmi_req_o, {7'h10, 2'd2, 32'h07FFFFC1});
    dmi_req_ready_i = 1'b1;
    idle(1);
    dmi_req_ready_i = 1'b0;
    check("wr accepted valid", dmi_req_valid_o, 0);
    check("wr wait resp_ready", dmi_resp_ready_o, 1);
    dmi_resp_i = {32'h0, 2'd0}; dmi_resp_valid_i = 1'b1;
    idle(1);
    dmi_resp_valid_i = 1'b0;
    check("wr done resp_ready", dmi_resp_ready_o, 0);
    check("wr req held after", dmi_req_o, {7'h10, 2'd2, 32'h07FFFFC1});

    // DMI read with ready and response valid arriving together.
    scan_dr(41, 64'(rd_req), dout, oe_ok);
    exp41 = {7'h10, 32'h0, 2'b00};
    check("rd capture", dout, 64'(exp41));
    check("rd valid", dmi_req_valid_o, 1);
    check("rd addr/op", dmi_req_o[40:32], {7'h10, 2'd1});
    dmi_req_ready_i = 1'b1; dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h4, 2'd0};
    idle(1);
    dmi_req_ready_i = 1'b0;
    check("rd coincide resp_ready", dmi_resp_ready_o, 1);
    check("rd coincide valid", dmi_req_valid_o, 0);
    idle(1);
    dmi_resp_valid_i = 1'b0;
    check("rd done resp_ready", dmi_resp_ready_o, 0);
    scan_dr(41, 64'h0, dout, oe_ok);
    exp41 = {7'h10, 32'h4, 2'b00};
    check("rd data capture", dout, 64'(exp41));

    // Busy: second scan while waiting for the read response.
    scan_dr(41, 64'(rd_req), dout, oe_ok);
    dmi_req_ready_i = 1'b1;
    idle(1);
    dmi_req_ready_i = 1'b0;
    scan_dr(41, 64'(wr_req), dout, oe_ok);
    exp41 = {7'h10, 32'h4, 2'b11};
    check("busy capture", dout, 64'(exp41));
    check("busy dropped valid", dmi_req_valid_o, 0);
    check("busy still waiting", dmi_resp_ready_o, 1);
    check("busy req op kept", dmi_req_o[33:32], 2'd1);
    dmi_resp_i = {32'h55, 2'd0}; dmi_resp_valid_i = 1'b1;
    idle(1);
    dmi_resp_valid_i = 1'b0;
    scan_dr(41, 64'h0, dout, oe_ok);
    exp41 = {7'h10, 32'h55, 2'b11};
    check("sticky busy capture", dout, 64'(exp41));
    scan_ir(5'h10, cap);
    scan_dr(32, 64'h0, dout, oe_ok);
    check("dtmcs busy", dout, 64'h1C71);
    scan_dr(32, 64'h0001_0000, dout, oe_ok);
    check("dtmcs busy before clear", dout, 64'h1C71);
    scan_dr(32, 64'h0, dout, oe_ok);
    check("dtmcs dmireset", dout, 64'h1071);

    // Failed response sets error 2.
    scan_ir(5'h11, cap);
    scan_dr(41, 64'(rd_req), dout, oe_ok);
    dmi_req_ready_i = 1'b1;
    idle(1);
    dmi_req_ready_i = 1'b0;
    dmi_resp_i = {32'h99, 2'd2}; dmi_resp_valid_i = 1'b1;
    idle(1);
    dmi_resp_valid_i = 1'b0;
    scan_ir(5'h10, cap);
    scan_dr(32, 64'h0001_0000, dout, oe_ok);
    check("dtmcs failed", dout, 64'h1871);
    scan_dr(32, 64'h0, dout, oe_ok);
    check("dtmcs failed cleared", dout, 64'h1071);

    // Hard reset while a request is pending.
    scan_ir(5'h11, cap);
    scan_dr(41, 64'(rd_req), dout, oe_ok);
    scan_ir(5'h10, cap);
    check("hard pre valid", dmi_req_valid_o, 1);
    clear_cnt = 0;
    scan_dr(32, 64'h0002_0000, dout, oe_ok);
    check("hard clear high", dmi_clear_o, 1);
    check("hard valid low", dmi_req_valid_o, 0);
    idle(3);
    check("hard clear pulses", clear_cnt, 1);
    check("hard clear low", dmi_clear_o, 0);
    check("hard resp_ready", dmi_resp_ready_o, 0);

    // Reset asserted in the middle of a DR scan.
    scan_ir(5'h11, cap);
    scan_dr(41, 64'(rd_req), dout, oe_ok);
    step(1'b1, 1'b0, b, oe);
    step(1'b0, 1'b0, b, oe);
    step(1'b0, 1'b0, b, oe);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, b, oe);
    check("midscan oe", tdo_oe_o, 1);
    trst_i = 1'b1;
    #1;
    check("trst td_o", td_o, 0);
    check("trst oe", tdo_oe_o, 0);
    check("trst valid", dmi_req_valid_o, 0);
    check("trst req", dmi_req_o, 0);
    #2;
    trst_i = 1'b0;
    step(1'b0, 1'b0, b, oe);
    scan_dr(32, 64'h0, dout, oe_ok);
    check("trst idcode", dout, 64'h1);
    scan_ir(5'h11, cap);
    scan_dr(41, 64'h0, dout, oe_ok);
    check("trst dmi cleared", dout, 0);

    // Five TMS=1 clocks return to Test-Logic-Reset and reload IDCODE.
    scan_ir(5'h10, cap);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, b, oe);
    step(1'b0, 1'b0, b, oe);
    scan_dr(32, 64'h0, dout, oe_ok);
    check("tms reset idcode", dout, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
